// File: rtl/instruction_fetch_queue.sv
// Fetch queue between the PC and decode: issues fetch requests to instruction memory,
// collects in-order responses into a circular buffer and drops stale responses after a flush.
module instruction_fetch_queue #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  readAddress,
  input  logic                   fetchValid,
  output logic                   fetchReady,
  input  logic                   flush,
  output logic                   memReqValid,
  output logic [ADDR_WIDTH-1:0]  memReqAddress,
  input  logic                   memReqReady,
  input  logic                   memRespValid,
  input  logic [INSTR_WIDTH-1:0] memRespData,
  output logic                   instrValid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  instrAddress,
  input  logic                   instrReady,
  output logic                   protocolError
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  ptr_t alloc_ptr, fill_ptr, head_ptr, drop_count;
  ptr_t used, pending;
  logic [ADDR_WIDTH-1:0]  addr_q [DEPTH];
  logic [INSTR_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]       filled_q;
  logic [IW-1:0]          alloc_idx, fill_idx, head_idx;
  logic [PW:0]            occupancy;
  logic [PW+1:0]          drop_sum;
  logic                   credit, fire, pop;

  assign used      = alloc_ptr - head_ptr;
  assign pending   = alloc_ptr - fill_ptr;
  assign alloc_idx = alloc_ptr[IW-1:0];
  assign fill_idx  = fill_ptr[IW-1:0];
  assign head_idx  = head_ptr[IW-1:0];

  // Stale responses still hold a slot until they drain, so they count against credit.
  assign occupancy = {1'b0, used} + {1'b0, drop_count};
  assign credit    = occupancy < DEPTH_W;
  assign drop_sum  = {2'b0, drop_count} + {2'b0, pending};

  assign memReqValid   = fetchValid & credit & ~flush & ~reset;
  assign memReqAddress = readAddress;
  assign fetchReady    = memReqValid & memReqReady;
  assign fire          = fetchReady;

  assign instrValid   = (used != '0) & filled_q[head_idx];
  assign instruction  = data_q[head_idx];
  assign instrAddress = addr_q[head_idx];
  assign pop          = instrValid & instrReady & ~flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      alloc_ptr     <= '0;
      fill_ptr      <= '0;
      head_ptr      <= '0;
      drop_count    <= '0;
      protocolError <= 1'b0;
      filled_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      head_ptr <= alloc_ptr;
      fill_ptr <= alloc_ptr;
      // A response arriving with the flush is itself one of the stale ones.
      if (memRespValid) begin
        if (drop_sum == '0) begin
          protocolError <= 1'b1;
          drop_count    <= '0;
        end else begin
          drop_count <= PW'(drop_sum - 1'b1);
        end
      end else begin
        drop_count <= PW'(drop_sum);
      end
    end else begin
      if (fire) begin
        addr_q[alloc_idx]   <= readAddress;
        filled_q[alloc_idx] <= 1'b0;
        alloc_ptr           <= alloc_ptr + ptr_t'(1);
      end
      if (memRespValid) begin
        if (drop_count != '0) begin
          drop_count <= drop_count - ptr_t'(1);
        end else if (pending != '0) begin
          data_q[fill_idx]   <= memRespData;
          filled_q[fill_idx] <= 1'b1;
          fill_ptr           <= fill_ptr + ptr_t'(1);
        end else begin
          protocolError <= 1'b1;
        end
      end
      if (pop) head_ptr <= head_ptr + ptr_t'(1);
    end
  end
endmodule
